// File: rtl/tree_stream_pkg.sv
// tree_stream_pkg: shared widths and state type for tree leaf-stage blocks
package tree_stream_pkg;
  localparam int TREE_DATA_W = 16;
  localparam int TREE_FANOUT = 5;
  typedef enum logic {ACCUM, HOLD} tree_acc_state_e;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/tree_node_accumulator_if.sv
// tree_node_accumulator_if: input word stream plus burst result channel
interface tree_node_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W = 3,
  parameter int SUM_W = 19
);
  logic s_valid;
  logic s_ready;
  logic [DATA_W-1:0] s_data;
  logic s_last;
  logic m_valid;
  logic m_ready;
  logic [SUM_W-1:0] m_sum;
  logic [CNT_W-1:0] m_beats;
  logic m_short;
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_sum, m_beats, m_short
  );
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_sum, m_beats, m_short
  );
endinterface

// File: rtl/tree_beat_counter.sv
// tree_beat_counter: saturating up-counter with synchronous clear
module tree_beat_counter #(
  parameter int MAX = 5,
  parameter int W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != W'(MAX)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/tree_node_accumulator.sv
// tree_node_accumulator: sums up to BURST_LEN stream words and holds one result per burst
module tree_node_accumulator
  import tree_stream_pkg::*;
#(
  parameter int DATA_W = TREE_DATA_W,
  parameter int BURST_LEN = TREE_FANOUT,
  localparam int CNT_W = cnt_width(BURST_LEN),
  localparam int SUM_W = DATA_W + CNT_W
) (
  input logic clk,
  input logic rst,
  tree_node_accumulator_if.slave bus
);
  tree_acc_state_e state, nxt;
  logic [SUM_W-1:0] acc, sum_next, sum_q;
  logic [CNT_W-1:0] cnt, beats_q;
  logic short_q, fire, full, close;
  tree_beat_counter #(.MAX(BURST_LEN), .W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(close),
    .inc(fire),
    .cnt(cnt)
  );
  // ready depends on state only, gated low while reset is asserted
  assign bus.s_ready = state == ACCUM && !rst;
  assign bus.m_valid = state == HOLD;
  assign bus.m_sum = sum_q;
  assign bus.m_beats = beats_q;
  assign bus.m_short = short_q;
  always_comb begin
    fire = bus.s_valid && bus.s_ready;
    full = cnt == CNT_W'(BURST_LEN - 1);
    close = fire && (full || bus.s_last);
    sum_next = acc + SUM_W'(bus.s_data);
    nxt = state == ACCUM ? (close ? HOLD : ACCUM) : (bus.m_ready ? ACCUM : HOLD);
  end
  always_ff @(posedge clk) begin
    state <= rst ? ACCUM : nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sum_q <= '0;
      beats_q <= '0;
      short_q <= 1'b0;
    end else if (close) begin
      acc <= '0;
      sum_q <= sum_next;
      beats_q <= cnt + 1'b1;
      short_q <= bus.s_last && !full;
    end else if (fire) begin
      acc <= sum_next;
    end
  end
endmodule

// File: tb/tb_tree_node_accumulator.sv
// tb_tree_node_accumulator: directed scoreboard bench for tree_node_accumulator
module tb_tree_node_accumulator;
  typedef struct packed {
    logic [18:0] sum;
    logic [2:0] beats;
    logic shrt;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  res_t q[$];
  int total = 0;
  int bad = 0;
  logic [18:0] macc;
  int mcnt;
  always #5 clk = ~clk;
  tree_node_accumulator_if #(.DATA_W(16), .CNT_W(3), .SUM_W(19)) bus ();
  tree_node_accumulator #(.DATA_W(16), .BURST_LEN(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    macc = '0;
    mcnt = 0;
    q.delete();
  endtask
  task automatic send(input logic [15:0] d, input logic l);
    int w = 0;
    logic took;
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.s_last = l;
    do begin
      took = bus.s_ready;
      @(negedge clk);
      w++;
    end while (!took && w < 20);
    chk("send_accepted", {31'b0, took}, 32'd1);
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    if (took) begin
      macc += 19'(d);
      mcnt++;
      if (mcnt == 5 || l) begin
        q.push_back('{macc, 3'(mcnt), l && mcnt < 5});
        macc = '0;
        mcnt = 0;
      end
    end
  endtask
  task automatic get_result(input int stall);
    int w = 0;
    res_t e;
    while (bus.m_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("m_valid_rise", 32'(bus.m_valid), 32'd1);
    if (q.size() == 0) begin
      chk("scoreboard_has_entry", 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    repeat (stall) begin
      chk("stall_sum", 32'(bus.m_sum), 32'(e.sum));
      chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
    end
    chk("m_sum", 32'(bus.m_sum), 32'(e.sum));
    chk("m_beats", 32'(bus.m_beats), 32'(e.beats));
    chk("m_short", 32'(bus.m_short), 32'(e.shrt));
    chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
    chk("hold_m_valid", 32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("post_hs_m_valid", 32'(bus.m_valid), 32'd0);
    chk("post_hs_s_ready", 32'(bus.s_ready), 32'd1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_sum", 32'(bus.m_sum), 32'd0);
    chk("rst_m_beats", 32'(bus.m_beats), 32'd0);
    chk("rst_m_short", 32'(bus.m_short), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
    clear_model();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b0;
    clear_model();
    @(negedge clk);
    do_reset();
    // full burst, result visible right after the fifth word
    for (int i = 1; i <= 5; i++) send(16'(i), 1'b0);
    chk("full_latency", 32'(bus.m_valid), 32'd1);
    get_result(0);
    send(16'd10, 1'b0);
    send(16'd20, 1'b1);
    get_result(0);
    for (int i = 6; i <= 10; i++) send(16'(i), 1'b0);
    get_result(4);
    repeat (5) send(16'hFFFF, 1'b0);
    get_result(0);
    // m_ready high during ACCUM must not produce a result
    bus.m_ready = 1'b1;
    send(16'd7, 1'b0);
    repeat (3) @(negedge clk);
    chk("ready_in_accum", 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b0;
    send(16'd8, 1'b0);
    send(16'd9, 1'b0);
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    get_result(0);
    send(16'd3, 1'b1);
    get_result(0);
    repeat (4) send(16'd1, 1'b0);
    send(16'd2, 1'b1);
    get_result(0);
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    do_reset();
    repeat (5) send(16'd4, 1'b0);
    get_result(0);
    for (int i = 1; i <= 5; i++) send(16'(i * 3), 1'b0);
    chk("hold_before_rst", 32'(bus.m_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_hold_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_in_hold_m_sum", 32'(bus.m_sum), 32'd0);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_in_hold_s_ready", 32'(bus.s_ready), 32'd1);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
